// File: rtl/vga_rect_fill_pkg.sv
// Shared definitions for the rectangle-fill engine.
// - Framebuffer geometry: FB_ROW_BYTES bytes per row, FB_ROWS rows.
// - MEM_SZ_* encodings carried in mem_ctrl_t.size.
// - mem_ctrl_t: framebuffer write-port control word.
// - fill_state_t: engine state encoding.
package vga_rect_fill_pkg;

  localparam int unsigned FB_ROW_BYTES = 80;
  localparam int unsigned FB_ROWS      = 120;

  localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
  localparam logic [1:0] MEM_SZ_HALF = 2'b01;
  localparam logic [1:0] MEM_SZ_WORD = 2'b10;

  typedef struct packed {
    logic       memRead;
    logic       memWrite;
    logic [1:0] size;
    logic       signExt;
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    StIdle,
    StClip,
    StFill,
    StDone
  } fill_state_t;

endpackage

// File: rtl/vga_fill_chunk.sv
// Combinational chunk selector for the fill engine.
// Picks the widest naturally aligned write that fits in the bytes left on the row.
// Ports:
//   i_x_lo  - low two bits of the current byte column
//   i_rem   - bytes remaining on the current row
//   o_size  - MEM_SZ_BYTE / MEM_SZ_HALF / MEM_SZ_WORD
//   o_bytes - chunk length in bytes (1, 2 or 4)
module vga_fill_chunk
  import vga_rect_fill_pkg::*;
(
  input  logic [1:0] i_x_lo,
  input  logic [7:0] i_rem,
  output logic [1:0] o_size,
  output logic [2:0] o_bytes
);

  always_comb begin
    o_size  = MEM_SZ_BYTE;
    o_bytes = 3'd1;
    if (i_x_lo == 2'b00 && i_rem >= 8'd4) begin
      o_size  = MEM_SZ_WORD;
      o_bytes = 3'd4;
    end else if (!i_x_lo[0] && i_rem >= 8'd2) begin
      o_size  = MEM_SZ_HALF;
      o_bytes = 3'd2;
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine driving the VGA framebuffer write port.
// Accepts one command (byte column/row origin, byte width, row height, colour),
// clips it to the framebuffer and emits byte/half/word writes of the replicated
// colour nibble, advancing only on granted cycles.
// Ports:
//   i_clk, i_rst_n            - clock, async active-low reset
//   i_cmdValid / o_cmdReady   - command handshake
//   i_bx0, i_by0, i_bw, i_bh  - rectangle origin and size (bytes, rows)
//   i_color                   - fill colour nibble
//   i_abort                   - cancel the running command (no o_done)
//   i_grant                   - write port granted this cycle
//   o_req                     - write pending
//   o_pxlAddr, o_pxlData      - write address {row, col} and data
//   o_ctrlVGA, o_en_MEM       - write-port control; strobes are o_req & i_grant
//   o_busy, o_done            - command in progress / completion pulse
module vga_rect_fill
  import vga_rect_fill_pkg::*;
#(
  parameter int unsigned ROW_BYTES = FB_ROW_BYTES,
  parameter int unsigned ROWS      = FB_ROWS
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmdValid,
  output logic        o_cmdReady,
  input  logic [7:0]  i_bx0,
  input  logic [6:0]  i_by0,
  input  logic [7:0]  i_bw,
  input  logic [7:0]  i_bh,
  input  logic [3:0]  i_color,
  input  logic        i_abort,
  input  logic        i_grant,
  output logic        o_req,
  output logic [31:0] o_pxlAddr,
  output logic [31:0] o_pxlData,
  output mem_ctrl_t   o_ctrlVGA,
  output logic        o_en_MEM,
  output logic        o_busy,
  output logic        o_done
);

  fill_state_t r_state;
  logic [7:0]  r_bx0, r_bw, r_bh, r_x, r_x_end;
  logic [6:0]  r_by0, r_y, r_y_end;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic [2:0]  r_bytes;
  logic        r_req, r_busy, r_done;

  logic [8:0]  w_sum_x, w_sum_y;
  logic [7:0]  w_clip_xe, w_adv_x, w_nx, w_xe, w_nrem;
  logic [6:0]  w_clip_ye, w_adv_y;
  logic        w_degen, w_row_end, w_last, w_wr;
  logic [1:0]  w_size;
  logic [2:0]  w_bytes;

  always_comb begin
    // 9-bit sums so an oversized rectangle clips instead of wrapping.
    w_sum_x   = {1'b0, r_bx0} + {1'b0, r_bw};
    w_sum_y   = {2'b00, r_by0} + {1'b0, r_bh};
    w_clip_xe = (w_sum_x > 9'(ROW_BYTES)) ? 8'(ROW_BYTES) : w_sum_x[7:0];
    w_clip_ye = (w_sum_y > 9'(ROWS)) ? 7'(ROWS) : w_sum_y[6:0];
    w_degen   = (r_bw == 8'd0) || (r_bh == 8'd0) ||
                (r_bx0 >= 8'(ROW_BYTES)) || (r_by0 >= 7'(ROWS));

    w_adv_x   = r_x + {5'd0, r_bytes};
    w_row_end = (w_adv_x == r_x_end);
    w_adv_y   = r_y + 7'd1;
    w_last    = w_row_end && (w_adv_y == r_y_end);

    // Next column and row end feed the chunk selector so size is registered
    // together with the address it belongs to.
    if (r_state == StClip) begin
      w_nx = r_bx0;
      w_xe = w_clip_xe;
    end else begin
      w_nx = w_row_end ? r_bx0 : w_adv_x;
      w_xe = r_x_end;
    end
    w_nrem = w_xe - w_nx;
  end

  vga_fill_chunk u_chunk (
    .i_x_lo  (w_nx[1:0]),
    .i_rem   (w_nrem),
    .o_size  (w_size),
    .o_bytes (w_bytes)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_bx0   <= '0;
      r_by0   <= '0;
      r_bw    <= '0;
      r_bh    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_x_end <= '0;
      r_y_end <= '0;
      r_data  <= '0;
      r_size  <= MEM_SZ_BYTE;
      r_bytes <= 3'd1;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_cmdValid) begin
            r_bx0   <= i_bx0;
            r_by0   <= i_by0;
            r_bw    <= i_bw;
            r_bh    <= i_bh;
            r_data  <= {8{i_color}};
            r_busy  <= 1'b1;
            r_state <= StClip;
          end
        end
        StClip: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (w_degen) begin
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_x     <= r_bx0;
            r_y     <= r_by0;
            r_x_end <= w_clip_xe;
            r_y_end <= w_clip_ye;
            r_size  <= w_size;
            r_bytes <= w_bytes;
            r_req   <= 1'b1;
            r_state <= StFill;
          end
        end
        StFill: begin
          if (i_abort) begin
            // A write granted this cycle still lands via the combinational strobe.
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else if (i_grant) begin
            if (w_last) begin
              r_req   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StDone;
            end else begin
              r_x     <= w_nx;
              r_y     <= w_row_end ? w_adv_y : r_y;
              r_size  <= w_size;
              r_bytes <= w_bytes;
            end
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign w_wr       = r_req & i_grant;
  assign o_req      = r_req;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_cmdReady = ~r_busy;
  assign o_pxlAddr  = {17'd0, r_y, r_x};
  assign o_pxlData  = r_data;
  assign o_en_MEM   = w_wr;

  always_comb begin
    o_ctrlVGA          = '0;
    o_ctrlVGA.memWrite = w_wr;
    o_ctrlVGA.size     = r_size;
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: full-row clear, unaligned fill, clipping,
// grant stalls, degenerate command, abort, and asynchronous reset mid-fill.
module tb_vga_rect_fill;
  import vga_rect_fill_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  bx0 = '0;
  logic [6:0]  by0 = '0;
  logic [7:0]  bw = '0;
  logic [7:0]  bh = '0;
  logic [3:0]  color = '0;
  logic        abort = 1'b0;
  logic        grant;
  logic        g_lvl = 1'b1;
  logic        g_tog = 1'b1;
  logic        stall_mode = 1'b0;
  logic        req, en_mem, busy, done;
  logic [31:0] addr, data;
  mem_ctrl_t   ctrl;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int gph = 0;

  logic [31:0] wa[$];
  logic [1:0]  ws[$];
  logic [31:0] wd[$];
  logic        wm[$];

  logic        p_req = 1'b0, p_gnt = 1'b0;
  logic [31:0] p_addr = '0;
  logic [1:0]  p_size = '0;

  assign grant = stall_mode ? g_tog : g_lvl;

  vga_rect_fill dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cmdValid (cmd_valid),
    .o_cmdReady (cmd_ready),
    .i_bx0      (bx0),
    .i_by0      (by0),
    .i_bw       (bw),
    .i_bh       (bh),
    .i_color    (color),
    .i_abort    (abort),
    .i_grant    (grant),
    .o_req      (req),
    .o_pxlAddr  (addr),
    .o_pxlData  (data),
    .o_ctrlVGA  (ctrl),
    .o_en_MEM   (en_mem),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Grant pattern 1,0,0,1,0,0,... used during the stall test.
  always begin
    @(posedge clk);
    #1;
    gph = (gph == 2) ? 0 : gph + 1;
    g_tog = (gph == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write log and done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (en_mem) begin
      wa.push_back(addr);
      ws.push_back(ctrl.size);
      wd.push_back(data);
      wm.push_back(ctrl.memWrite);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (stall_mode) begin
      if (req && !grant) chk("stall_nowrite", {31'd0, ctrl.memWrite}, 32'd0);
      if (p_req && !p_gnt && req) begin
        chk("stall_addr_hold", addr, p_addr);
        chk("stall_size_hold", {30'd0, ctrl.size}, {30'd0, p_size});
      end
    end
    p_req  = req;
    p_gnt  = grant;
    p_addr = addr;
    p_size = ctrl.size;
  end

  task automatic clear_log();
    wa.delete();
    ws.delete();
    wd.delete();
    wm.delete();
  endtask

  // Called just after a rising edge; returns #1 after the accept edge.
  task automatic start_cmd(input logic [7:0] x, input logic [6:0] y, input logic [7:0] w,
                           input logic [7:0] h, input logic [3:0] c);
    bx0 = x; by0 = y; bw = w; bh = h; color = c;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    cmd_valid = 1'b0;
    // Scramble command inputs; the engine must ignore them now.
    bx0 = 8'd3; by0 = 7'd7; bw = 8'd1; bh = 8'd1; color = 4'hF;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int start;
    start = done_cnt;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk);
      #1;
      if (done_cnt != start) break;
    end
    chk(tag, done_cnt - start, 1);
  endtask

  initial begin
    logic [31:0] ea[8];
    logic [1:0]  es[8];
    int base_done;
    int nw;

    // Reset values
    #12;
    chk("rst_cmdReady", {31'd0, cmd_ready}, 32'd1);
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_ctrl", {27'd0, ctrl}, 32'd0);
    chk("rst_en", {31'd0, en_mem}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full-row clear: 20 word writes
    clear_log();
    start_cmd(8'd0, 7'd0, 8'd80, 8'd1, 4'h5);
    chk("full_busy", {31'd0, busy}, 32'd1);
    chk("full_notready", {31'd0, cmd_ready}, 32'd0);
    wait_done(40, "full_done_seen");
    chk("full_done_time", done_cyc - acc, 32'd21);
    chk("full_ready_after", {31'd0, cmd_ready}, 32'd1);
    chk("full_count", wa.size(), 32'd20);
    for (int i = 0; i < wa.size() && i < 20; i++) begin
      chk("full_addr", wa[i], 32'(4 * i));
      chk("full_size", {30'd0, ws[i]}, {30'd0, MEM_SZ_WORD});
      chk("full_data", wd[i], 32'h5555_5555);
      chk("full_memwrite", {31'd0, wm[i]}, 32'd1);
    end

    // Unaligned: byte, half, half, byte
    clear_log();
    start_cmd(8'd1, 7'd2, 8'd6, 8'd1, 4'hA);
    wait_done(20, "unal_done_seen");
    chk("unal_done_time", done_cyc - acc, 32'd5);
    ea[0] = 32'h201; ea[1] = 32'h202; ea[2] = 32'h204; ea[3] = 32'h206;
    es[0] = MEM_SZ_BYTE; es[1] = MEM_SZ_HALF; es[2] = MEM_SZ_HALF; es[3] = MEM_SZ_BYTE;
    chk("unal_count", wa.size(), 32'd4);
    for (int i = 0; i < wa.size() && i < 4; i++) begin
      chk("unal_addr", wa[i], ea[i]);
      chk("unal_size", {30'd0, ws[i]}, {30'd0, es[i]});
      chk("unal_data", wd[i], 32'hAAAA_AAAA);
    end

    // Clip at bottom-right corner: one half write
    clear_log();
    start_cmd(8'd78, 7'd119, 8'd10, 8'd5, 4'h3);
    wait_done(20, "clip_done_seen");
    chk("clip_count", wa.size(), 32'd1);
    if (wa.size() > 0) begin
      chk("clip_addr", wa[0], 32'h774E);
      chk("clip_size", {30'd0, ws[0]}, {30'd0, MEM_SZ_HALF});
    end

    // Grant stall: two rows with grant 1,0,0,...
    clear_log();
    stall_mode = 1'b1;
    start_cmd(8'd1, 7'd3, 8'd6, 8'd2, 4'h6);
    wait_done(60, "stall_done_seen");
    stall_mode = 1'b0;
    ea[0] = 32'h301; ea[1] = 32'h302; ea[2] = 32'h304; ea[3] = 32'h306;
    ea[4] = 32'h401; ea[5] = 32'h402; ea[6] = 32'h404; ea[7] = 32'h406;
    es[0] = MEM_SZ_BYTE; es[1] = MEM_SZ_HALF; es[2] = MEM_SZ_HALF; es[3] = MEM_SZ_BYTE;
    es[4] = MEM_SZ_BYTE; es[5] = MEM_SZ_HALF; es[6] = MEM_SZ_HALF; es[7] = MEM_SZ_BYTE;
    chk("stall_count", wa.size(), 32'd8);
    for (int i = 0; i < wa.size() && i < 8; i++) begin
      chk("stall_addr", wa[i], ea[i]);
      chk("stall_size", {30'd0, ws[i]}, {30'd0, es[i]});
      chk("stall_data", wd[i], 32'h6666_6666);
    end

    // Degenerate: bw=0
    clear_log();
    start_cmd(8'd5, 7'd5, 8'd0, 8'd3, 4'h1);
    wait_done(10, "degen_done_seen");
    chk("degen_done_time", done_cyc - acc, 32'd1);
    chk("degen_count", wa.size(), 32'd0);

    // Abort after 3 writes, grant low in the abort cycle
    clear_log();
    base_done = done_cnt;
    start_cmd(8'd0, 7'd10, 8'd4, 8'd4, 4'h7);
    nw = 0;
    for (int k = 0; k < 20 && nw < 3; k++) begin
      @(posedge clk);
      #1;
      nw = wa.size();
    end
    abort = 1'b1;
    g_lvl = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b0;
    g_lvl = 1'b1;
    chk("abort0_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort0_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("abort0_count", wa.size(), 32'd3);
    chk("abort0_nodone", done_cnt, base_done);
    if (wa.size() == 3) chk("abort0_addr2", wa[2], 32'hC00);

    // Abort after 3 writes, grant high: 4th (last) write lands, still no done
    clear_log();
    base_done = done_cnt;
    start_cmd(8'd0, 7'd10, 8'd4, 8'd4, 4'h7);
    nw = 0;
    for (int k = 0; k < 20 && nw < 3; k++) begin
      @(posedge clk);
      #1;
      nw = wa.size();
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort1_ready", {31'd0, cmd_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("abort1_count", wa.size(), 32'd4);
    chk("abort1_nodone", done_cnt, base_done);
    if (wa.size() == 4) chk("abort1_addr3", wa[3], 32'hD00);

    // Asynchronous reset mid-fill
    clear_log();
    start_cmd(8'd0, 7'd0, 8'd80, 8'd1, 4'h9);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, req}, 32'd0);
    chk("arst_memwrite", {31'd0, ctrl.memWrite}, 32'd0);
    chk("arst_en", {31'd0, en_mem}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    nw = wa.size();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("arst_nowrites", wa.size(), nw);
    @(posedge clk);
    #1;
    clear_log();
    start_cmd(8'd1, 7'd2, 8'd6, 8'd1, 4'hA);
    wait_done(20, "arst_done_seen");
    chk("arst_count", wa.size(), 32'd4);
    if (wa.size() == 4) chk("arst_addr3", wa[3], 32'h206);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_rect_fill.md
# vga_rect_fill

Hardware rectangle-fill engine that drives the framebuffer write port of the VGA colour block, so that clears and solid boxes take no CPU store loop. It accepts one rectangle command at a time. It emits a stream of byte, halfword and word framebuffer writes carrying the colour nibble replicated across the data word. It sits beside the CPU store path behind a bus grant.

## Interface
- `ROW_BYTES`, 80: framebuffer bytes per row; 160 px, 2 px per byte.
- `ROWS`, 120: framebuffer rows.
- `i_clk` in 1: sole clock, same domain as the framebuffer write port.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_cmdValid` in 1: command present.
- `o_cmdReady` out 1: engine idle and able to accept a command.
- `i_bx0` in 8: start byte column, 0..79.
- `i_by0` in 7: start row, 0..119.
- `i_bw` in 8: width in bytes.
- `i_bh` in 8: height in rows.
- `i_color` in 4: fill colour nibble.
- `i_abort` in 1: cancel the current command.
- `i_grant` in 1: write port granted this cycle.
- `o_req` out 1: a write is pending.
- `o_pxlAddr` out 32: framebuffer write address. Bits [14:8] hold the row, [7:0] hold the byte column, all other bits are 0.
- `o_pxlData` out 32: `{8{i_color}}`, latched at accept.
- `o_ctrlVGA` out `mem_ctrl_t`: `.memWrite` equals `o_req & i_grant`; `.size` is 00 for byte, 01 for half, 10 for word. All other fields are 0.
- `o_en_MEM` out 1: equals `o_req & i_grant`.
- `o_busy` out 1: a command is in progress.
- `o_done` out 1: one-cycle pulse when a command completes normally.

## Operation
- States and transitions:
  - IDLE: `o_cmdReady` is 1. On `i_cmdValid`, latch the command and go to CLIP.
  - CLIP: one cycle. Compute `x_end = min(bx0+bw, ROW_BYTES)` and `y_end = min(by0+bh, ROWS)`. Compute with 9-bit sums, no wrap. If `bw==0`, `bh==0`, `bx0>=ROW_BYTES` or `by0>=ROWS`, go to DONE. Otherwise go to FILL with `x=bx0`, `y=by0`.
  - FILL: `o_req` is 1. Chunk selection by remaining bytes `rem = x_end - x`:
    - word if `x[1:0]==0` and `rem>=4`;
    - else half if `x[0]==0` and `rem>=2`;
    - else byte.
  - FILL advance: on a granted cycle, `x += chunk bytes`. If the new `x==x_end`, then `x=bx0` and `y++`. If the new `y==y_end`, go to DONE.
  - FILL stall: `i_grant` low holds `o_pxlAddr` and `.size` stable and issues no write.
  - DONE: one cycle with `o_done=1`, then IDLE.
- `i_abort` is honoured in CLIP or FILL. It goes straight to IDLE next cycle with no `o_done`. Any write granted in the abort cycle still completes.
- `o_busy` is 1 in CLIP, FILL and DONE.
- Command inputs are sampled only on the accept edge. Later changes are ignored.
- Reset values: state IDLE, `o_req=0`, `o_done=0`, `o_busy=0`, `o_cmdReady=1`, `o_pxlAddr=0`, `o_pxlData=0`, `o_ctrlVGA` all zero, `o_en_MEM=0`.

## Timing
- Accept at edge T, when `i_cmdValid & o_cmdReady`.
- CLIP runs in cycle T+1, and the first write is presented in T+2.
- With `i_grant` held high, there is one write per cycle. For a command needing N writes, `o_done` is high in cycle T+2+N.
- `o_cmdReady` returns high the cycle after `o_done`.
- Degenerate commands give `o_done` at T+2 and produce no writes.
- `o_pxlAddr`, `.size` and `o_req` are registered. Only `memWrite` and `o_en_MEM` depend combinationally on `i_grant`.
- Reset asserted mid-FILL clears everything immediately. No further writes are issued.

## Structure
- The shared package gains:
  - `FB_ROW_BYTES`, `FB_ROWS`;
  - size encodings `MEM_SZ_BYTE/HALF/WORD`;
  - a `fill_state_t` enum.
- `mem_ctrl_t` is reused unchanged from the package.
- One sub-module, `vga_fill_chunk`: combinational chunk selector. Inputs are `x[1:0]` and `rem`; outputs are `size` and chunk bytes (1/2/4).

## Test plan
- Full-row clear: `bx0=0`, `by0=0`, `bw=80`, `bh=1`, colour 5, grant always high → 20 word writes, addresses 0x000..0x04C in steps of 4, data 0x55555555, `o_done` at T+22.
- Unaligned: `bx0=1`, `by0=2`, `bw=6`, `bh=1`, colour A → byte@0x201, half@0x202, half@0x204, byte@0x206, data 0xAAAAAAAA.
- Clip: `bx0=78`, `by0=119`, `bw=10`, `bh=5` → a single half write @0x774E, then `o_done`. No address has row ≥120 or column ≥80.
- Grant stall: two-row fill with `i_grant` toggling 1,0,0,1,… → address and size are held during low cycles. There are no duplicate or missing writes, and the total write count matches the ungated run.
- Degenerate or abort: `bw=0` → `o_done` at T+2 with zero writes. A 4-row fill aborted after 3 writes → no `o_done`, `o_cmdReady` high the next cycle, exactly 3 or 4 writes depending on grant in the abort cycle.
- Reset mid-FILL: deassert `i_rst_n` asynchronously → `o_req`, `memWrite` and `o_busy` go to 0 at once. After release, `o_cmdReady=1` and a new command runs normally.
